multiword_add_sequencer: RTL and testbench

MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

---
 rtl/adder_pkg.sv | 15 +
 rtl/ripple_carry_adder.sv | 32 +++
 rtl/multiword_add_sequencer.sv | 146 ++++++++++++++
 tb/tb_multiword_add_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for adder controllers: FSM state encoding and index sizing.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } adder_state_t;

   // A single-word operand still needs a 1-bit index register.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Combinational DATA_WIDTH-bit ripple-carry adder with optional signed-overflow output.
module ripple_carry_adder #(
   parameter int DATA_WIDTH     = 16,
   parameter bit OVERFLOW_LOGIC = 1'b1
) (
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   input  logic                  i_cin,
   output logic [DATA_WIDTH-1:0] o_sum,
   output logic                  o_cout,
   output logic                  o_ovf
);

   logic [DATA_WIDTH:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_fa
      assign o_sum[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
      assign w_c[g+1]   = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
   end

   assign o_cout = w_c[DATA_WIDTH];

   // Overflow: carry into the MSB disagrees with carry out of it.
   if (OVERFLOW_LOGIC) begin : g_ovf
      assign o_ovf = w_c[DATA_WIDTH] ^ w_c[DATA_WIDTH-1];
   end else begin : g_no_ovf
      assign o_ovf = 1'b0;
   end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Word-serial W-bit add/subtract: one DATA_WIDTH adder reused over NUM_WORDS cycles,
// with valid/ready handshakes on both the request and the result.
module multiword_add_sequencer
   import adder_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_WORDS  = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [DATA_WIDTH*NUM_WORDS-1:0] A,
   input  logic [DATA_WIDTH*NUM_WORDS-1:0] B,
   input  logic                           sub,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [DATA_WIDTH*NUM_WORDS-1:0] S,
   output logic                           CF,
   output logic                           OF,
   output logic                           busy
);

   localparam int W     = DATA_WIDTH * NUM_WORDS;
   localparam int IDX_W = idx_width(NUM_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   adder_state_t r_state;
   adder_state_t w_state_nxt;

   logic [W-1:0]          r_a;
   logic [W-1:0]          r_b;
   logic                  r_carry;
   logic [IDX_W-1:0]      r_idx;
   logic [DATA_WIDTH-1:0] r_s_words [NUM_WORDS];
   logic                  r_cf;
   logic                  r_of;

   logic                  w_accept;
   logic                  w_last;
   logic [DATA_WIDTH-1:0] w_a_words [NUM_WORDS];
   logic [DATA_WIDTH-1:0] w_b_words [NUM_WORDS];
   logic [DATA_WIDTH-1:0] w_a_word;
   logic [DATA_WIDTH-1:0] w_b_word;
   logic [DATA_WIDTH-1:0] w_sum;
   logic                  w_cout;
   logic                  w_ovf;

   for (genvar g = 0; g < NUM_WORDS; g++) begin : g_words
      assign w_a_words[g]                      = r_a[g*DATA_WIDTH +: DATA_WIDTH];
      assign w_b_words[g]                      = r_b[g*DATA_WIDTH +: DATA_WIDTH];
      assign S[g*DATA_WIDTH +: DATA_WIDTH]     = r_s_words[g];
   end

   assign w_a_word = w_a_words[r_idx];
   assign w_b_word = w_b_words[r_idx];
   assign w_last   = (r_idx == LAST_IDX);
   assign CF       = r_cf;
   assign OF       = r_of;

   ripple_carry_adder #(
      .DATA_WIDTH     (DATA_WIDTH),
      .OVERFLOW_LOGIC (1'b1)
   ) u_rca (
      .i_a    (w_a_word),
      .i_b    (w_b_word),
      .i_cin  (r_carry),
      .o_sum  (w_sum),
      .o_cout (w_cout),
      .o_ovf  (w_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (w_last) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Subtraction is A + ~B + 1: invert B here and seed the carry with sub.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_a <= A;
         r_b <= sub ? ~B : B;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_carry <= 1'b0;
         r_idx   <= '0;
         r_cf    <= 1'b0;
         r_of    <= 1'b0;
         for (int i = 0; i < NUM_WORDS; i++) begin
            r_s_words[i] <= '0;
         end
      end else if (w_accept) begin
         r_carry <= sub;
         r_idx   <= '0;
      end else if (r_state == RUN) begin
         r_s_words[r_idx] <= w_sum;
         r_carry          <= w_cout;
         if (w_last) begin
            r_cf <= w_cout;
            r_of <= w_ovf;
         end else begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed-vector bench for multiword_add_sequencer at DATA_WIDTH=16, NUM_WORDS=4.
module tb_multiword_add_sequencer;

   localparam int DW = 16;
   localparam int NW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [63:0]   A;
   logic [63:0]   B;
   logic          sub;
   logic          out_valid;
   logic          out_ready;
   logic [63:0]   S;
   logic          CF;
   logic          OF;
   logic          busy;

   int total = 0;
   int bad   = 0;

   multiword_add_sequencer #(
      .DATA_WIDTH (DW),
      .NUM_WORDS  (NW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .CF        (CF),
      .OF        (OF),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic s);
      int n;
      check("in_ready_idle", 64'(in_ready), 64'd1);
      A = a;
      B = b;
      sub = s;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      check("latency", 64'(n), 64'd4);
   endtask

   task automatic finish_op(input string tag, input logic [63:0] es, input logic ecf, input logic eof);
      check({tag, "_S"},  S,        es);
      check({tag, "_CF"}, 64'(CF),  64'(ecf));
      check({tag, "_OF"}, 64'(OF),  64'(eof));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_idle"}, 64'({in_ready, out_valid, busy}), 64'b100);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      A         = '0;
      B         = '0;
      sub       = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_ctrl", 64'({in_ready, out_valid, busy}), 64'b100);
      check("rst_S",    S, 64'd0);
      check("rst_flags", 64'({CF, OF}), 64'd0);

      start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
      finish_op("add_carry_word", 64'h0000_0000_0001_0000, 1'b0, 1'b0);

      start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
      finish_op("add_wrap", 64'h0, 1'b1, 1'b0);

      start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
      finish_op("add_ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1);

      start_op(64'h5, 64'h7, 1'b1);
      finish_op("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);

      start_op(64'h7, 64'h5, 1'b1);
      finish_op("sub_pos", 64'h2, 1'b1, 1'b0);

      // Result held under back-pressure while new requests are offered.
      start_op(64'h1234, 64'h1111, 1'b0);
      A = 64'hAAAA; B = 64'h1; sub = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_S",    S, 64'h2345);
         check("hold_ctrl", 64'({in_ready, out_valid, busy, CF, OF}), 64'b01100);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("release_ctrl", 64'({in_ready, out_valid, busy}), 64'b100);
      check("release_S",    S, 64'h2345);
      tick();
      check("no_accept", 64'(busy), 64'd0);

      // Reset while RUN is at word index 2.
      A = 64'h1111_2222_3333_4444; B = 64'h1; sub = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("mid_busy",    64'(busy), 64'd1);
      check("mid_partial", S, 64'h0000_0000_3333_4445);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_ctrl", 64'({in_ready, out_valid, busy}), 64'b100);
      check("midrst_S",    S, 64'd0);
      check("midrst_flags", 64'({CF, OF}), 64'd0);

      start_op(64'h1, 64'h1, 1'b0);
      finish_op("after_rst", 64'h2, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
